// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier, unsigned or signed, start/rdy handshake
module mul_seq #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            sgn,
   input  logic            start,
   output logic [BITS-1:0] p_hi,
   output logic [BITS-1:0] p_lo,
   output logic            ovf,
   output logic            rdy
);

   localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t              state_q;
   logic [2*BITS-1:0]   mcand_q;
   logic [BITS-1:0]     mplier_q;
   logic [2*BITS-1:0]   acc_q;
   logic [CW-1:0]       cnt_q;
   logic                neg_q;
   logic                sgn_q;
   logic [BITS-1:0]     p_hi_q;
   logic [BITS-1:0]     p_lo_q;
   logic                ovf_q;
   logic                rdy_q;

   logic [BITS-1:0]     a_mag_d;
   logic [BITS-1:0]     b_mag_d;
   logic [2*BITS-1:0]   acc_d;
   logic [2*BITS-1:0]   res_d;
   logic                ovf_d;

   // Operand magnitudes, next partial sum, and the sign-corrected final result
   always_comb begin
      a_mag_d = (sgn && a[BITS-1]) ? -a : a;
      b_mag_d = (sgn && b[BITS-1]) ? -b : b;
      acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
      res_d   = neg_q ? -acc_q : acc_q;
      if (sgn_q) begin
         ovf_d = (res_d[2*BITS-1:BITS] != {BITS{res_d[BITS-1]}});
      end else begin
         ovf_d = (res_d[2*BITS-1:BITS] != '0);
      end
   end

   // Control FSM and datapath; a start in any state restarts the operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         sgn_q    <= 1'b0;
         p_hi_q   <= '0;
         p_lo_q   <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{BITS{1'b0}}, a_mag_d};
         mplier_q <= b_mag_d;
         neg_q    <= sgn & (a[BITS-1] ^ b[BITS-1]);
         sgn_q    <= sgn;
         acc_q    <= '0;
         cnt_q    <= '0;
         rdy_q    <= 1'b0;
         state_q  <= RUN;
      end else begin
         case (state_q)
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               p_hi_q  <= res_d[2*BITS-1:BITS];
               p_lo_q  <= res_d[BITS-1:0];
               ovf_q   <= ovf_d;
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign p_hi = p_hi_q;
   assign p_lo = p_lo_q;
   assign ovf  = ovf_q;
   assign rdy  = rdy_q & ~start;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        sgn;
   logic        start;
   logic [31:0] p_hi;
   logic [31:0] p_lo;
   logic        ovf;
   logic        rdy;

   int checks;
   int errors;

   mul_seq #(.BITS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .sgn   (sgn),
      .start (start),
      .p_hi  (p_hi),
      .p_lo  (p_lo),
      .ovf   (ovf),
      .rdy   (rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one edge; caller is positioned just after a rising edge
   task automatic do_start(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      a = av;
      b = bv;
      sgn = sv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after the start edge until rdy rises (bounded)
   task automatic wait_rdy(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (rdy) break;
      end
   endtask

   task automatic test_reset;
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL reset_p_hi got %h exp 0", p_hi); end
      checks++; if (p_lo !== 32'h0) begin errors++; $display("FAIL reset_p_lo got %h exp 0", p_lo); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
   endtask

   task automatic test_unsigned_basic;
      int cyc;
      do_start(32'd6, 32'd7, 1'b0);
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL basic_latency got %0d exp 33", cyc); end
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL basic_p_hi got %h exp 0", p_hi); end
      checks++; if (p_lo !== 32'd42) begin errors++; $display("FAIL basic_p_lo got %h exp 2a", p_lo); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
   endtask

   task automatic test_unsigned_max;
      int cyc;
      do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL umax_latency got %0d exp 33", cyc); end
      checks++; if (p_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umax_p_hi got %h exp fffffffe", p_hi); end
      checks++; if (p_lo !== 32'h0000_0001) begin errors++; $display("FAIL umax_p_lo got %h exp 00000001", p_lo); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL umax_ovf got %b exp 1", ovf); end
   endtask

   task automatic test_signed_mixed;
      int cyc;
      do_start(32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL smix_latency got %0d exp 33", cyc); end
      checks++; if (p_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL smix_p_hi got %h exp ffffffff", p_hi); end
      checks++; if (p_lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL smix_p_lo got %h exp ffffffeb", p_lo); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL smix_ovf got %b exp 0", ovf); end
   endtask

   task automatic test_signed_corner;
      int cyc;
      do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL scorner_latency got %0d exp 33", cyc); end
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL scorner_p_hi got %h exp 0", p_hi); end
      checks++; if (p_lo !== 32'h8000_0000) begin errors++; $display("FAIL scorner_p_lo got %h exp 80000000", p_lo); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL scorner_ovf got %b exp 1", ovf); end
   endtask

   task automatic test_restart;
      int cyc;
      bit early;
      bit saw25;
      // rdy is 1 from the previous op; raising start must hide it at once
      a = 32'd5;
      b = 32'd5;
      sgn = 1'b0;
      start = 1'b1;
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL restart_rdy_in_start_cycle got %b exp 0", rdy); end
      @(posedge clk);
      #1;
      start = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         if (rdy !== 1'b0) early = 1'b1;
      end
      do_start(32'd3, 32'd4, 1'b0);
      cyc = 0;
      saw25 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (p_lo === 32'd25) saw25 = 1'b1;
         if (rdy) break;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL restart_early_rdy got %b exp 0", early); end
      checks++; if (cyc !== 33) begin errors++; $display("FAIL restart_latency got %0d exp 33", cyc); end
      checks++; if (saw25 !== 1'b0) begin errors++; $display("FAIL restart_stale_25 got %b exp 0", saw25); end
      checks++; if (p_lo !== 32'd12) begin errors++; $display("FAIL restart_p_lo got %h exp 0c", p_lo); end
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL restart_p_hi got %h exp 0", p_hi); end
   endtask

   task automatic test_held_start;
      int cyc;
      a = 32'd2;
      b = 32'd9;
      sgn = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL held_latency got %0d exp 33", cyc); end
      checks++; if (p_lo !== 32'd18) begin errors++; $display("FAIL held_p_lo got %h exp 12", p_lo); end
   endtask

   task automatic test_reset_midop;
      int cyc;
      do_start(32'd5, 32'd7, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL midrst_p_hi got %h exp 0", p_hi); end
      checks++; if (p_lo !== 32'h0) begin errors++; $display("FAIL midrst_p_lo got %h exp 0", p_lo); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b exp 0", rdy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got %b exp 0", rdy); end
      do_start(32'd0, 32'h1234, 1'b0);
      wait_rdy(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL midrst_latency got %0d exp 33", cyc); end
      checks++; if (p_hi !== 32'h0) begin errors++; $display("FAIL midrst_after_p_hi got %h exp 0", p_hi); end
      checks++; if (p_lo !== 32'h0) begin errors++; $display("FAIL midrst_after_p_lo got %h exp 0", p_lo); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_after_ovf got %b exp 0", ovf); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      a = '0;
      b = '0;
      sgn = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_unsigned_basic();
      test_unsigned_max();
      test_signed_mixed();
      test_signed_corner();
      test_restart();
      test_held_start();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
